// File: rtl/npu_pkg.sv
// ============================================================
// npu_pkg : shared Q8.8 datapath constants, FSM state encoding
//           and the product saturation helper.
// Rev 1.0
// ============================================================
`default_nettype none

package npu_pkg;

  localparam int DATA_W = 16;
  localparam int Q_FRAC = 8;
  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_DRAIN = 3'd2,
    S_BIAS  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return Q_MAX;
    else if (v < -32'sd32768)
      return Q_MIN;
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/m16_bit.sv
// ============================================================
// m16_bit : 16-bit signed saturating adder (17-bit sum, clamped).
// Rev 1.0
// ============================================================
`default_nettype none

module m16_bit
  import npu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  logic signed [DATA_W:0] wide;

  assign wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};

  always_comb begin
    sum = wide[DATA_W-1:0];
    if (wide[DATA_W] != wide[DATA_W-1])
      sum = wide[DATA_W] ? Q_MIN : Q_MAX;
  end

endmodule

`default_nettype wire

// File: rtl/neuron_mac_acc.sv
// ============================================================
// neuron_mac_acc : Q8.8 multiply-accumulate for one neuron, bias add,
//                  optional ReLU, valid/ready result.
// Rev 1.0
// ============================================================
`default_nettype none

module neuron_mac_acc
  import npu_pkg::*;
#(
  parameter int N_INPUTS = 784,
  parameter int FRAC     = 8,
  parameter int RELU     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic [DATA_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc, p_reg, bias_reg;
  logic              p_vld;

  logic               accept, last, out_hs;
  logic signed [31:0] prod, prod_sh;
  logic [DATA_W-1:0]  p_next, add_b, add_sum, wrap_sum;
  logic               prod_clamp, add_en, add_clamp;

  assign in_ready  = (state == S_IDLE) || (state == S_ACCUM);
  assign out_valid = (state == S_OUT);
  assign accept    = in_valid && in_ready;
  assign last      = accept && (cnt == CNT_W'(N_INPUTS - 1));
  assign out_hs    = out_valid && out_ready;

  assign prod       = $signed(in_data) * $signed(in_weight);
  assign prod_sh    = prod >>> FRAC;
  assign p_next     = sat16(prod_sh);
  assign prod_clamp = (prod_sh > 32'sd32767) || (prod_sh < -32'sd32768);

  // Pending product and bias add never overlap, so one adder serves both.
  assign add_b  = (state == S_BIAS) ? bias_reg : p_reg;
  assign add_en = p_vld || (state == S_BIAS);

  m16_bit u_add (
    .a   (acc),
    .b   (add_b),
    .sum (add_sum)
  );

  // Overflow is visible as a clamped result whose wrapped sum flipped sign.
  assign wrap_sum  = acc + add_b;
  assign add_clamp = ((add_sum == Q_MAX) && !acc[DATA_W-1] && !add_b[DATA_W-1] &&  wrap_sum[DATA_W-1]) ||
                     ((add_sum == Q_MIN) &&  acc[DATA_W-1] &&  add_b[DATA_W-1] && !wrap_sum[DATA_W-1]);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = last ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (last)   state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_BIAS;
      S_BIAS:  state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      p_reg    <= '0;
      p_vld    <= 1'b0;
      bias_reg <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_nxt;
      p_vld <= accept;
      if (accept) begin
        p_reg <= p_next;
        cnt   <= cnt + 1'b1;
        if (state == S_IDLE)
          bias_reg <= bias;
      end
      if (p_vld)
        acc <= add_sum;
      if (state == S_BIAS)
        out_data <= ((RELU != 0) && add_sum[DATA_W-1]) ? '0 : add_sum;
      if (out_hs) begin
        acc     <= '0;
        cnt     <= '0;
        out_sat <= 1'b0;
      end else if ((accept && prod_clamp) || (add_en && add_clamp)) begin
        out_sat <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_acc.sv
// ============================================================
// tb_neuron_mac_acc : directed scoreboard bench over four configurations.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_neuron_mac_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_v  [4];
  logic        in_ready_v  [4];
  logic [15:0] in_data_v   [4];
  logic [15:0] in_weight_v [4];
  logic [15:0] bias_v      [4];
  logic        out_valid_v [4];
  logic        out_ready_v [4];
  logic [15:0] out_data_v  [4];
  logic        out_sat_v   [4];

  int nvec  = 0;
  int nfail = 0;

  logic [16:0] exp_q[$];
  logic [15:0] d_arr [8];
  logic [15:0] w_arr [8];

  always #5 clk = ~clk;

  // Instances: 0 = N4 ReLU, 1 = N4 linear, 2 = N1 ReLU, 3 = N8 linear
  for (genvar g = 0; g < 4; g++) begin : g_dut
    neuron_mac_acc #(
      .N_INPUTS (g == 2 ? 1 : (g == 3 ? 8 : 4)),
      .FRAC     (8),
      .RELU     ((g == 1 || g == 3) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_data   (in_data_v[g]),
      .in_weight (in_weight_v[g]),
      .bias      (bias_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_data  (out_data_v[g]),
      .out_sat   (out_sat_v[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] m_sat(input int v);
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  function automatic logic [16:0] m_prod(input logic [15:0] d, input logic [15:0] w);
    int p;
    p = $signed(d) * $signed(w);
    return m_sat(p >>> 8);
  endfunction

  function automatic logic [16:0] m_add(input logic [15:0] a, input logic [15:0] b);
    return m_sat(int'($signed(a)) + int'($signed(b)));
  endfunction

  task automatic send(input int idx, input logic [15:0] d, input logic [15:0] w, input logic [15:0] b);
    int guard;
    guard = 0;
    in_valid_v[idx]  = 1'b1;
    in_data_v[idx]   = d;
    in_weight_v[idx] = w;
    bias_v[idx]      = b;
    while (!in_ready_v[idx] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 32'(in_ready_v[idx]), 32'd1);
    @(posedge clk); #1;
    in_valid_v[idx] = 1'b0;
  endtask

  // Models the neuron, pushes the expectation, then streams the pairs.
  task automatic feed(input int idx, input int n, input logic [15:0] b, input int max_gap);
    logic [15:0] acc;
    logic [16:0] r;
    logic        sat;
    acc = '0;
    sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = m_prod(d_arr[i], w_arr[i]);
      sat |= r[16];
      r = m_add(acc, r[15:0]);
      sat |= r[16];
      acc = r[15:0];
    end
    r = m_add(acc, b);
    sat |= r[16];
    acc = r[15:0];
    if ((idx == 0 || idx == 2) && acc[15]) acc = '0;
    exp_q.push_back({sat, acc});
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      send(idx, d_arr[i], w_arr[i], b);
    end
  endtask

  task automatic collect(input int idx, input int hold, output logic [15:0] got);
    int lat;
    logic [16:0] e;
    logic [15:0] d0;
    logic        s0;
    lat = 1;
    got = 'x;
    while (!out_valid_v[idx] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    if (out_valid_v[idx] && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_data", 32'(out_data_v[idx]), 32'(e[15:0]));
      chk("out_sat", 32'(out_sat_v[idx]), 32'(e[16]));
      got = out_data_v[idx];
      d0  = out_data_v[idx];
      s0  = out_sat_v[idx];
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(out_valid_v[idx]), 32'd1);
        chk("hold_data", 32'(out_data_v[idx]), 32'(d0));
        chk("hold_sat", 32'(out_sat_v[idx]), 32'(s0));
        chk("hold_in_ready", 32'(in_ready_v[idx]), 32'd0);
      end
      out_ready_v[idx] = 1'b1;
      @(posedge clk); #1;
      out_ready_v[idx] = 1'b0;
      chk("in_ready_after_hs", 32'(in_ready_v[idx]), 32'd1);
      chk("valid_after_hs", 32'(out_valid_v[idx]), 32'd0);
    end
  endtask

  task automatic fill(input logic [15:0] d, input logic [15:0] w);
    for (int i = 0; i < 8; i++) begin
      d_arr[i] = d;
      w_arr[i] = w;
    end
  endtask

  initial begin
    logic [15:0] got, ref_sum;
    for (int i = 0; i < 4; i++) begin
      in_valid_v[i]  = 1'b0;
      in_data_v[i]   = '0;
      in_weight_v[i] = '0;
      bias_v[i]      = '0;
      out_ready_v[i] = 1'b0;
    end
    #12;
    chk("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
    chk("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("rst_out_data", 32'(out_data_v[0]), 32'd0);
    chk("rst_out_sat", 32'(out_sat_v[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 4 x (1.0 * 1.0) + 0.5
    fill(16'h0100, 16'h0100);
    feed(0, 4, 16'h0080, 0);
    collect(0, 0, got);
    chk("basic_abs", 32'(got), 32'h0480);

    // Accumulator saturation, then a clean neuron clears out_sat
    fill(16'h7000, 16'h0100);
    feed(0, 4, 16'h0000, 0);
    collect(0, 0, got);
    chk("sat_abs", 32'(got), 32'h7FFF);
    fill(16'h0080, 16'h0100);
    feed(0, 4, 16'h0010, 0);
    collect(0, 0, got);
    chk("after_sat_abs", 32'(got), 32'h0210);

    // Negative sum with and without ReLU
    fill(16'h0100, 16'hFF00);
    feed(0, 4, 16'h0000, 0);
    collect(0, 0, got);
    chk("relu_abs", 32'(got), 32'h0000);
    feed(1, 4, 16'h0000, 0);
    collect(1, 0, got);
    chk("linear_abs", 32'(got), 32'hFC00);

    // Single-pair neuron with a clamped product
    fill(16'h7FFF, 16'h7FFF);
    feed(2, 1, 16'h0000, 0);
    collect(2, 0, got);
    chk("n1_abs", 32'(got), 32'h7FFF);

    // Gap-free vs gapped stream on an 8-pair neuron
    for (int i = 0; i < 8; i++) begin
      d_arr[i] = 16'($urandom_range(16'h0300, 0)) - 16'h0180;
      w_arr[i] = 16'($urandom_range(16'h0200, 0)) - 16'h0100;
    end
    feed(3, 8, 16'h0040, 0);
    collect(3, 0, ref_sum);
    feed(3, 8, 16'h0040, 2);
    collect(3, 0, got);
    chk("gap_equal", 32'(got), 32'(ref_sum));

    // Backpressure on the result
    fill(16'h0200, 16'h0080);
    feed(0, 4, 16'h0000, 0);
    collect(0, 5, got);

    // Abort mid-neuron
    fill(16'h0100, 16'h0100);
    send(0, 16'h0100, 16'h0100, 16'h0000);
    send(0, 16'h0100, 16'h0100, 16'h0000);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready_v[0]), 32'd1);
    chk("abort_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("abort_out_data", 32'(out_data_v[0]), 32'd0);
    chk("abort_out_sat", 32'(out_sat_v[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    feed(0, 4, 16'h0000, 0);
    collect(0, 0, got);
    chk("post_abort_abs", 32'(got), 32'h0400);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
